// File: rtl/game_pkg.sv
// game_pkg: shared board geometry, tile constants, scanner states and tile helpers.
package game_pkg;
  localparam int TILES = 16;
  localparam int TILE_W = 4;
  localparam int BOARD_W = TILES * TILE_W;
  localparam logic [TILE_W-1:0] WIN_TILE = 4'd11;
  localparam logic [TILE_W-1:0] EMPTY_TILE = 4'd0;
  localparam logic [3:0] LAST_IDX = 4'd15;
  typedef enum logic [1:0] {S_IDLE, S_SNAP, S_ISSUE, S_WAIT_ACK} scan_state_t;
  function automatic logic [TILE_W-1:0] max2(input logic [TILE_W-1:0] a, input logic [TILE_W-1:0] b);
    return a > b ? a : b;
  endfunction
  // Tile 0 lives in the top nibble, so tile i starts at bit 4*(15-i) = {~i, 2'b00}.
  function automatic logic [TILE_W-1:0] tile_at(input logic [BOARD_W-1:0] b, input logic [3:0] i);
    return b[{~i, 2'b00} +: TILE_W];
  endfunction
endpackage

// File: rtl/tile_max.sv
// tile_max: combinational balanced max tree over the 16 board tiles.
module tile_max import game_pkg::*; (
  input  logic [BOARD_W-1:0] board,
  output logic [TILE_W-1:0]  max_tile
);
  logic [TILE_W-1:0] l1 [8];
  logic [TILE_W-1:0] l2 [4];
  logic [TILE_W-1:0] l3 [2];
  for (genvar i = 0; i < 8; i++) begin : g_l1
    assign l1[i] = max2(board[(2*i)*TILE_W +: TILE_W], board[(2*i+1)*TILE_W +: TILE_W]);
  end
  for (genvar i = 0; i < 4; i++) begin : g_l2
    assign l2[i] = max2(l1[2*i], l1[2*i+1]);
  end
  for (genvar i = 0; i < 2; i++) begin : g_l3
    assign l3[i] = max2(l2[2*i], l2[2*i+1]);
  end
  assign max_tile = max2(l3[0], l3[1]);
endmodule

// File: rtl/board_store.sv
// board_store: game board register with move counter, best tile and a tile-serial drawer scanner.
module board_store import game_pkg::*; #(
  parameter int CNT_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               update,
  input  logic [BOARD_W-1:0] newvalues,
  output logic [BOARD_W-1:0] oldvalues,
  output logic               changed,
  output logic [CNT_W-1:0]   moves,
  output logic [TILE_W-1:0]  best_tile,
  output logic               draw_req,
  output logic [3:0]         draw_idx,
  output logic [TILE_W-1:0]  draw_val,
  input  logic               draw_ack,
  output logic               busy
);
  scan_state_t state, state_nx;
  logic [BOARD_W-1:0] snap, snap_nx;
  logic [3:0] idx, idx_nx, draw_idx_nx;
  logic [TILE_W-1:0] draw_val_nx, max_now;
  logic pending, load_diff, ack_take, draw_req_nx;
  assign load_diff = update && (newvalues != oldvalues);
  assign ack_take = draw_req && draw_ack;
  assign busy = (state != S_IDLE) || pending;
  tile_max u_max (.board(oldvalues), .max_tile(max_now));
  always_ff @(posedge clock) begin
    if (reset) begin
      oldvalues <= '0;
      changed <= 1'b0;
      moves <= '0;
      best_tile <= EMPTY_TILE;
      pending <= 1'b1;
    end else begin
      if (update) oldvalues <= newvalues;
      changed <= load_diff;
      if (load_diff && !(&moves)) moves <= moves + 1'b1;
      best_tile <= max_now;
      // A load on the snapshot edge keeps pending set so the new board is rescanned.
      pending <= load_diff || (pending && state != S_SNAP);
    end
  end
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state == S_IDLE  ? (pending ? S_SNAP : S_IDLE) :
               state == S_SNAP  ? S_ISSUE :
               state == S_ISSUE ? S_WAIT_ACK :
               ack_take         ? (idx == LAST_IDX ? S_IDLE : S_ISSUE) : S_WAIT_ACK;
  end
  always_comb begin
    snap_nx = state == S_SNAP ? oldvalues : snap;
    idx_nx = state == S_SNAP ? 4'd0 :
             (state == S_WAIT_ACK && ack_take && idx != LAST_IDX) ? idx + 4'd1 : idx;
    draw_req_nx = state == S_ISSUE ? 1'b1 : (state == S_WAIT_ACK && ack_take) ? 1'b0 : draw_req;
    draw_idx_nx = state == S_ISSUE ? idx : draw_idx;
    draw_val_nx = state == S_ISSUE ? tile_at(snap, idx) : draw_val;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      snap <= '0;
      idx <= 4'd0;
      draw_req <= 1'b0;
      draw_idx <= 4'd0;
      draw_val <= EMPTY_TILE;
    end else begin
      snap <= snap_nx;
      idx <= idx_nx;
      draw_req <= draw_req_nx;
      draw_idx <= draw_idx_nx;
      draw_val <= draw_val_nx;
    end
  end
endmodule

// File: doc/board_store.md
Name: board_store

Overview:
- Holds the 4x4 game board of 16 4-bit tile exponents.
- Sits on the far side of the game control block's update/newvalues/oldvalues interface:
  - latches newvalues when update pulses;
  - drives oldvalues back to the control block.
- Also keeps a move counter and the highest tile.
- Serializes changed boards tile-by-tile to the display drawer over a req/ack handshake.

Parameters:
- TILES, 16, number of board tiles (fixed 4x4; other values unsupported).
- TILE_W, 4, bits per tile exponent (0 = empty, 11 = 2048).
- CNT_W, 16, width of the move counter.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- update  in  1  load strobe from the control block, single-cycle or level.
- newvalues  in  64  next board; tile 0 = [63:60], tile 15 = [3:0].
- oldvalues  out  64  current board, same packing.
- changed  out  1  one-cycle pulse when a load altered the board.
- moves  out  CNT_W  count of loads that changed the board.
- best_tile  out  4  maximum tile exponent on the current board.
- draw_req  out  1  drawer request, valid tile on draw_idx/draw_val.
- draw_idx  out  4  tile index 0..15 being drawn.
- draw_val  out  4  tile exponent being drawn.
- draw_ack  in  1  drawer accepted the current tile.
- busy  out  1  a scan is in progress or pending.

Behaviour:
- Reset values:
  - oldvalues = 0, changed = 0, moves = 0, best_tile = 0;
  - draw_req = 0, draw_idx = 0, draw_val = 0;
  - scan pending = 1, so a full clearing scan starts after reset. busy = 1 from the first cycle after reset.
- Load:
  - On a clock edge with update = 1, board <= newvalues; oldvalues reflects it the next cycle (1-cycle latency).
  - If newvalues != board:
    - changed pulses for exactly one cycle;
    - moves increments, saturating at all-ones;
    - pending is set.
  - Identical loads have no effect beyond the register write.
  - Level-held update reloads every cycle. Only cycles where the value differs count.
- best_tile: registered max of all 16 tiles of the board. Valid one cycle after oldvalues updates.
- Scanner FSM states: IDLE, SNAP, ISSUE, WAIT_ACK.
  - IDLE: if pending -> SNAP.
  - SNAP:
    - copy board into a 64-bit snapshot;
    - clear pending;
    - idx <= 0;
    - -> ISSUE.
  - ISSUE: draw_req <= 1, draw_idx <= idx, draw_val <= snapshot tile idx; -> WAIT_ACK.
  - WAIT_ACK:
    - hold req/idx/val stable until draw_ack = 1.
    - On ack, draw_req <= 0.
    - If idx = 15 -> IDLE, else idx++ -> ISSUE.
  - One tile per handshake. Minimum 2 cycles per tile.
- Handshake rules:
  - draw_req never drops without ack.
  - draw_ack while draw_req = 0 is ignored.
  - draw_ack held high gives back-to-back tiles at 2 cycles each.
- Mid-scan update: the snapshot is not disturbed, so there is no torn frame. pending is set and a fresh full scan follows immediately after the current one ends.
  - Multiple updates during one scan coalesce into one rescan.
- Simultaneous events:
  - Update on the same edge as SNAP: the snapshot takes the pre-update board, and pending stays set (set wins over clear).
  - Update on the same edge as reset: reset wins.
- Reset mid-scan:
  - draw_req drops next cycle;
  - board clears;
  - a clearing scan restarts from idx 0.
- busy = (state != IDLE) | pending.

Decomposition:
- Shared package (game_pkg):
  - TILE_W, TILES, WIN_TILE = 11, EMPTY_TILE = 0;
  - scanner state encoding.
- Sub-module tile_max: combinational 16-input 4-bit max tree, instantiated for best_tile and registered in board_store.

Test Plan:
- Reset, drawer acks immediately -> draw_req/idx steps 0..15 with draw_val = 0 each; busy falls after the 16th ack; moves = 0.
- update with newvalues = 0x1000_0000_0000_0001 from the zero board -> changed pulses 1 cycle; moves = 1; oldvalues matches next cycle; best_tile = 1; one scan shows tile 0 = 1 and tile 15 = 1.
- Same newvalues loaded again -> changed = 0, moves stays 1, no new scan (busy = 0).
- Start a scan; at idx 5 load a board with tile 3 = 11 -> remaining scan shows the old snapshot. A second full scan follows with tile 3 = 11 and best_tile = 11.
- Drawer delays ack 7 cycles per tile -> draw_req/idx/val stable throughout each wait; no skipped or repeated index.
- Preload moves to 0xFFFE, then 3 changing loads -> moves = 0xFFFF and holds.
